ex_stage_m: RTL and testbench

//  Parametrised RV32IM execute stage; successor to the single-cycle EX stage.

---
 rtl/ex_pkg.sv | 46 ++++
 rtl/ex_divider.sv | 125 ++++++++++++
 rtl/ex_stage_m.sv | 168 ++++++++++++++++
 tb/tb_ex_stage_m.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU controls, M-extension ops,
// branch conditions and divider FSM states.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_ctrl_e;

  // Values equal the RV32M funct3 field
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_f3_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with 1-cycle shortcuts.
// Optional macro EX_DIV_EARLY_OUT_EN: also shortcut when |dividend| < |divisor|.
module ex_divider
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            abort,
  input  logic            hold,
  output logic            stall,
  output logic            res_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state_q, state_d;

  logic [XLEN-1:0] rem_q, quo_q, dsr_q;
  logic [CW-1:0]   cnt_q;
  logic            is_rem_q, neg_quo_q, neg_rem_q;

  logic            is_signed, is_rem, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, overflow, early, shortcut, start;
  logic [XLEN-1:0] short_result;
  logic [XLEN:0]   shifted, diff;
  logic            fits;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    is_signed = ~op[0];
    is_rem    = op[1];
    a_neg     = is_signed & dividend[XLEN-1];
    b_neg     = is_signed & divisor[XLEN-1];
    a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
    div_zero  = (divisor == '0);
    overflow  = is_signed & (dividend == MIN_VAL) & (divisor == '1);
`ifdef EX_DIV_EARLY_OUT_EN
    early     = (a_mag < b_mag);
`else
    early     = 1'b0;
`endif
    shortcut  = div_zero | overflow | early;
    // Priority: zero divisor, then MIN/-1, then small dividend
    if (div_zero)
      short_result = is_rem ? dividend : '1;
    else if (overflow)
      short_result = is_rem ? '0 : MIN_VAL;
    else
      short_result = is_rem ? dividend : '0;
    start = req & ~abort & ~shortcut & (state_q == DIV_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= DIV_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start) state_d = DIV_BUSY;
      DIV_BUSY: begin
        if (abort)
          state_d = DIV_IDLE;
        else if (cnt_q == LAST_STEP)
          state_d = DIV_DONE;
      end
      DIV_DONE: if (abort || !hold) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dsr_q};
    fits    = ~diff[XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (start) begin
      rem_q     <= '0;
      quo_q     <= a_mag;
      dsr_q     <= b_mag;
      cnt_q     <= '0;
      is_rem_q  <= is_rem;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
    end else if (state_q == DIV_BUSY) begin
      rem_q <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    quo_fix   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    stall     = ((state_q == DIV_IDLE) & req & ~shortcut) | (state_q == DIV_BUSY);
    res_valid = ((state_q == DIV_IDLE) & req & shortcut) | (state_q == DIV_DONE);
    result    = (state_q == DIV_DONE) ? (is_rem_q ? rem_fix : quo_fix) : short_result;
  end

endmodule

// File: rtl/ex_stage_m.sv
// RV32IM execute stage: operand forwarding, ALU, single-cycle multiply, branch
// resolution, iterative divider and the EX/MEM register. Optional macro: EX_DIV_EARLY_OUT_EN.
module ex_stage_m
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int N_FWD = 2,
  parameter int FSW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_in,
  input  logic                  flush_in,
  input  logic                  mem_stall_in,
  output logic                  ex_stall_out,
  input  logic [XLEN-1:0]       id_pc_in,
  input  logic [XLEN-1:0]       id_pc_plus_4_in,
  input  logic [XLEN-1:0]       id_rs1_in,
  input  logic [XLEN-1:0]       id_rs2_in,
  input  logic [XLEN-1:0]       id_imm_in,
  input  logic [4:0]            id_rd_addr_in,
  input  logic [N_FWD*XLEN-1:0] fwd_data_in,
  input  logic [FSW-1:0]        forward_a_in,
  input  logic [FSW-1:0]        forward_b_in,
  input  logic                  id_alu_src_in,
  input  logic [3:0]            id_alu_ctrl_in,
  input  logic                  id_muldiv_in,
  input  logic [2:0]            id_muldiv_op_in,
  input  logic                  id_branch_in,
  input  logic [2:0]            id_br_funct3_in,
  input  logic                  id_mem_read_in,
  input  logic                  id_mem_write_in,
  input  logic                  id_reg_write_in,
  input  logic [1:0]            id_mem_to_reg_in,
  output logic                  ex_valid_out,
  output logic [XLEN-1:0]       ex_result_out,
  output logic [XLEN-1:0]       ex_rs2_out,
  output logic [XLEN-1:0]       ex_pc_plus_4_out,
  output logic [4:0]            ex_rd_addr_out,
  output logic                  ex_mem_read_out,
  output logic                  ex_mem_write_out,
  output logic                  ex_reg_write_out,
  output logic [1:0]            ex_mem_to_reg_out,
  output logic                  ex_branch_taken_out,
  output logic [XLEN-1:0]       ex_branch_target_out
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0]   op_a, op_b, alu_b, alu_res, mul_res, ex_res;
  logic [SHW-1:0]    shamt;
  logic              a_sext, b_sext;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic              br_cond, is_div, div_req, div_stall, div_res_valid;
  logic [XLEN-1:0]   div_result;

  // Selects outside 1..N_FWD fall through to the register file value
  always_comb begin
    op_a = id_rs1_in;
    op_b = id_rs2_in;
    for (int k = 0; k < N_FWD; k++) begin
      if (forward_a_in == FSW'(k + 1)) op_a = fwd_data_in[k*XLEN +: XLEN];
      if (forward_b_in == FSW'(k + 1)) op_b = fwd_data_in[k*XLEN +: XLEN];
    end
  end

  always_comb begin
    alu_b = id_alu_src_in ? id_imm_in : op_b;
    shamt = alu_b[SHW-1:0];
    case (id_alu_ctrl_in)
      ALU_ADD:    alu_res = op_a + alu_b;
      ALU_SUB:    alu_res = op_a - alu_b;
      ALU_SLL:    alu_res = op_a << shamt;
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(alu_b)};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, op_a < alu_b};
      ALU_XOR:    alu_res = op_a ^ alu_b;
      ALU_SRL:    alu_res = op_a >> shamt;
      ALU_SRA:    alu_res = $signed(op_a) >>> shamt;
      ALU_OR:     alu_res = op_a | alu_b;
      ALU_AND:    alu_res = op_a & alu_b;
      ALU_PASS_B: alu_res = alu_b;
      default:    alu_res = '0;
    endcase
  end

  // One 2*XLEN multiplier; operand extension picks signed/mixed/unsigned
  always_comb begin
    a_sext  = (id_muldiv_op_in == MD_MULH) || (id_muldiv_op_in == MD_MULHSU);
    b_sext  = (id_muldiv_op_in == MD_MULH);
    mul_a   = {{XLEN{a_sext & op_a[XLEN-1]}}, op_a};
    mul_b   = {{XLEN{b_sext & op_b[XLEN-1]}}, op_b};
    product = mul_a * mul_b;
    mul_res = (id_muldiv_op_in == MD_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  always_comb begin
    case (id_br_funct3_in)
      BR_BEQ:  br_cond = (op_a == op_b);
      BR_BNE:  br_cond = (op_a != op_b);
      BR_BLT:  br_cond = ($signed(op_a) < $signed(op_b));
      BR_BGE:  br_cond = ($signed(op_a) >= $signed(op_b));
      BR_BLTU: br_cond = (op_a < op_b);
      BR_BGEU: br_cond = (op_a >= op_b);
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    is_div  = id_valid_in & id_muldiv_in & id_muldiv_op_in[2];
    div_req = is_div & ~flush_in;
    if (id_muldiv_in)
      ex_res = id_muldiv_op_in[2] ? div_result : mul_res;
    else
      ex_res = alu_res;
  end

  ex_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .req       (div_req),
    .op        (id_muldiv_op_in[1:0]),
    .dividend  (op_a),
    .divisor   (op_b),
    .abort     (flush_in),
    .hold      (mem_stall_in),
    .stall     (div_stall),
    .res_valid (div_res_valid),
    .result    (div_result)
  );

  assign ex_stall_out = ~flush_in & (mem_stall_in | div_stall);

  // EX/MEM register: flush beats downstream hold; a divider stall inserts a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_out         <= 1'b0;
      ex_result_out        <= '0;
      ex_rs2_out           <= '0;
      ex_pc_plus_4_out     <= '0;
      ex_rd_addr_out       <= '0;
      ex_mem_read_out      <= 1'b0;
      ex_mem_write_out     <= 1'b0;
      ex_reg_write_out     <= 1'b0;
      ex_mem_to_reg_out    <= '0;
      ex_branch_taken_out  <= 1'b0;
      ex_branch_target_out <= '0;
    end else if (flush_in || (!mem_stall_in && div_stall)) begin
      ex_valid_out        <= 1'b0;
      ex_mem_read_out     <= 1'b0;
      ex_mem_write_out    <= 1'b0;
      ex_reg_write_out    <= 1'b0;
      ex_branch_taken_out <= 1'b0;
    end else if (!mem_stall_in) begin
      ex_valid_out         <= id_valid_in & (~is_div | div_res_valid);
      ex_result_out        <= ex_res;
      ex_rs2_out           <= op_b;
      ex_pc_plus_4_out     <= id_pc_plus_4_in;
      ex_rd_addr_out       <= id_rd_addr_in;
      ex_mem_read_out      <= id_valid_in & id_mem_read_in;
      ex_mem_write_out     <= id_valid_in & id_mem_write_in;
      ex_reg_write_out     <= id_valid_in & id_reg_write_in;
      ex_mem_to_reg_out    <= id_mem_to_reg_in;
      ex_branch_taken_out  <= id_valid_in & id_branch_in & br_cond;
      ex_branch_target_out <= id_pc_in + id_imm_in;
    end
  end

endmodule

// File: tb/tb_ex_stage_m.sv
// Directed self-checking bench for ex_stage_m (default XLEN=32, N_FWD=2).
// Expected values are hand-computed constants.
module tb_ex_stage_m;
  import ex_pkg::*;

  logic        clk, rst;
  logic        id_valid_in, flush_in, mem_stall_in, ex_stall_out;
  logic [31:0] id_pc_in, id_pc_plus_4_in, id_rs1_in, id_rs2_in, id_imm_in;
  logic [4:0]  id_rd_addr_in;
  logic [63:0] fwd_data_in;
  logic [1:0]  forward_a_in, forward_b_in;
  logic        id_alu_src_in;
  logic [3:0]  id_alu_ctrl_in;
  logic        id_muldiv_in;
  logic [2:0]  id_muldiv_op_in;
  logic        id_branch_in;
  logic [2:0]  id_br_funct3_in;
  logic        id_mem_read_in, id_mem_write_in, id_reg_write_in;
  logic [1:0]  id_mem_to_reg_in;
  logic        ex_valid_out;
  logic [31:0] ex_result_out, ex_rs2_out, ex_pc_plus_4_out;
  logic [4:0]  ex_rd_addr_out;
  logic        ex_mem_read_out, ex_mem_write_out, ex_reg_write_out;
  logic [1:0]  ex_mem_to_reg_out;
  logic        ex_branch_taken_out;
  logic [31:0] ex_branch_target_out;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage_m #(.XLEN(32), .N_FWD(2), .FSW(2)) dut (
    .clk(clk), .rst(rst), .id_valid_in(id_valid_in), .flush_in(flush_in),
    .mem_stall_in(mem_stall_in), .ex_stall_out(ex_stall_out),
    .id_pc_in(id_pc_in), .id_pc_plus_4_in(id_pc_plus_4_in),
    .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in), .id_imm_in(id_imm_in),
    .id_rd_addr_in(id_rd_addr_in), .fwd_data_in(fwd_data_in),
    .forward_a_in(forward_a_in), .forward_b_in(forward_b_in),
    .id_alu_src_in(id_alu_src_in), .id_alu_ctrl_in(id_alu_ctrl_in),
    .id_muldiv_in(id_muldiv_in), .id_muldiv_op_in(id_muldiv_op_in),
    .id_branch_in(id_branch_in), .id_br_funct3_in(id_br_funct3_in),
    .id_mem_read_in(id_mem_read_in), .id_mem_write_in(id_mem_write_in),
    .id_reg_write_in(id_reg_write_in), .id_mem_to_reg_in(id_mem_to_reg_in),
    .ex_valid_out(ex_valid_out), .ex_result_out(ex_result_out),
    .ex_rs2_out(ex_rs2_out), .ex_pc_plus_4_out(ex_pc_plus_4_out),
    .ex_rd_addr_out(ex_rd_addr_out), .ex_mem_read_out(ex_mem_read_out),
    .ex_mem_write_out(ex_mem_write_out), .ex_reg_write_out(ex_reg_write_out),
    .ex_mem_to_reg_out(ex_mem_to_reg_out),
    .ex_branch_taken_out(ex_branch_taken_out),
    .ex_branch_target_out(ex_branch_target_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] alu, input logic src,
                               input logic md, input logic [2:0] mdop,
                               input logic br, input logic [2:0] f3,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [1:0] fa, input logic [1:0] fb);
    id_valid_in      = valid;
    id_alu_ctrl_in   = alu;
    id_alu_src_in    = src;
    id_muldiv_in     = md;
    id_muldiv_op_in  = mdop;
    id_branch_in     = br;
    id_br_funct3_in  = f3;
    id_rs1_in        = rs1;
    id_rs2_in        = rs2;
    id_imm_in        = imm;
    forward_a_in     = fa;
    forward_b_in     = fb;
    id_pc_in         = 32'h100;
    id_pc_plus_4_in  = 32'h104;
    id_rd_addr_in    = 5'd5;
    id_mem_read_in   = 1'b0;
    id_mem_write_in  = 1'b0;
    id_reg_write_in  = ~br;
    id_mem_to_reg_in = 2'b01;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic runDivide(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res,
                           input int exp_edges, input int exp_stalls);
    int  edges  = 0;
    int  stalls = 0;
    logic got   = 1'b0;
    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b1, op, 1'b0, 3'b0, a, b, 32'h0, 2'd0, 2'd0);
    while (!got && edges < 100) begin
      #2;
      if (ex_stall_out) stalls++;
      stepClock();
      edges++;
      if (ex_valid_out) got = 1'b1;
    end
    checkOutput({tag, " edges"}, 32'(edges), 32'(exp_edges));
    checkOutput({tag, " stalls"}, 32'(stalls), 32'(exp_stalls));
    checkOutput({tag, " result"}, ex_result_out, exp_res);
    applyStimulus(1'b0, ALU_ADD, 1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 0, 0, 0, 2'd0, 2'd0);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    flush_in = 1'b0;
    mem_stall_in = 1'b0;
    fwd_data_in = {32'd30, 32'd5};
    applyStimulus(1'b0, ALU_ADD, 1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 0, 0, 0, 2'd0, 2'd0);
    stepClock();
    checkOutput("reset valid", 32'(ex_valid_out), 32'd0);
    checkOutput("reset result", ex_result_out, 32'd0);
    checkOutput("reset stall", 32'(ex_stall_out), 32'd0);
    checkOutput("reset target", ex_branch_target_out, 32'd0);
    rst = 1'b0;
    stepClock();

    // ALU and forwarding
    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 32'd99, 32'd7, 0, 2'd1, 2'd0);
    stepClock();
    checkOutput("add fwd mem", ex_result_out, 32'd12);
    checkOutput("add valid", 32'(ex_valid_out), 32'd1);
    checkOutput("add reg_write", 32'(ex_reg_write_out), 32'd1);
    checkOutput("add rd", 32'(ex_rd_addr_out), 32'd5);

    mem_stall_in = 1'b1;
    applyStimulus(1'b1, ALU_SUB, 1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 32'd100, 32'd1, 0, 2'd0, 2'd2);
    #1;
    checkOutput("mem stall forces stall", 32'(ex_stall_out), 32'd1);
    stepClock();
    checkOutput("mem stall holds result", ex_result_out, 32'd12);
    mem_stall_in = 1'b0;
    stepClock();
    checkOutput("sub fwd wb", ex_result_out, 32'd70);
    checkOutput("rs2 fwd wb", ex_rs2_out, 32'd30);

    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 32'd9, 32'd1, 0, 2'd3, 2'd0);
    stepClock();
    checkOutput("fwd sel 3 uses regfile", ex_result_out, 32'd10);
    applyStimulus(1'b1, ALU_ADD, 1'b1, 1'b0, 3'b0, 1'b0, 3'b0, 32'd10, 32'd0, 32'hFFFF_FFFD, 2'd0, 2'd0);
    stepClock();
    checkOutput("add imm", ex_result_out, 32'd7);
    applyStimulus(1'b1, ALU_SRA, 1'b1, 1'b0, 3'b0, 1'b0, 3'b0, 32'h8000_0000, 32'd0, 32'd4, 2'd0, 2'd0);
    stepClock();
    checkOutput("sra", ex_result_out, 32'hF800_0000);
    applyStimulus(1'b1, ALU_SLT, 1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 32'hFFFF_FFFF, 32'd1, 0, 2'd0, 2'd0);
    stepClock();
    checkOutput("slt", ex_result_out, 32'd1);

    // Multiplier
    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b1, MD_MUL, 1'b0, 3'b0, 32'hFFFF_FFFD, 32'd5, 0, 2'd0, 2'd0);
    stepClock();
    checkOutput("mul", ex_result_out, 32'hFFFF_FFF1);
    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b1, MD_MULH, 1'b0, 3'b0, 32'h8000_0000, 32'h8000_0000, 0, 2'd0, 2'd0);
    stepClock();
    checkOutput("mulh", ex_result_out, 32'h4000_0000);
    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b1, MD_MULHSU, 1'b0, 3'b0, 32'hFFFF_FFFF, 32'd2, 0, 2'd0, 2'd0);
    stepClock();
    checkOutput("mulhsu", ex_result_out, 32'hFFFF_FFFF);
    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b1, MD_MULHU, 1'b0, 3'b0, 32'hFFFF_FFFF, 32'd2, 0, 2'd0, 2'd0);
    stepClock();
    checkOutput("mulhu", ex_result_out, 32'd1);

    // Branches
    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b0, 3'b0, 1'b1, BR_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 2'd0, 2'd0);
    stepClock();
    checkOutput("blt taken", 32'(ex_branch_taken_out), 32'd1);
    checkOutput("blt target", ex_branch_target_out, 32'h120);
    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b0, 3'b0, 1'b1, BR_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 2'd0, 2'd0);
    stepClock();
    checkOutput("bltu not taken", 32'(ex_branch_taken_out), 32'd0);
    applyStimulus(1'b0, ALU_ADD, 1'b0, 1'b0, 3'b0, 1'b1, BR_BEQ, 32'd4, 32'd4, 32'h20, 2'd0, 2'd0);
    stepClock();
    checkOutput("invalid beq not taken", 32'(ex_branch_taken_out), 32'd0);
    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b0, 3'b0, 1'b1, BR_BEQ, 32'd4, 32'd4, 32'h20, 2'd0, 2'd0);
    flush_in = 1'b1;
    mem_stall_in = 1'b1;
    stepClock();
    checkOutput("flushed beq not taken", 32'(ex_branch_taken_out), 32'd0);
    checkOutput("flushed beq valid", 32'(ex_valid_out), 32'd0);
    flush_in = 1'b0;
    mem_stall_in = 1'b0;

    // Divider
    runDivide("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 33);
    runDivide("rem -7/2", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 33);
    runDivide("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 33);
    runDivide("rem 7/-2", MD_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 33);
    runDivide("divu 9/0", MD_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 0);
    runDivide("remu 9/0", MD_REMU, 32'd9, 32'd0, 32'd9, 1, 0);
    runDivide("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    runDivide("rem min/-1", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
`ifdef EX_DIV_EARLY_OUT_EN
    runDivide("divu 3/10", MD_DIVU, 32'd3, 32'd10, 32'd0, 1, 0);
`else
    runDivide("divu 3/10", MD_DIVU, 32'd3, 32'd10, 32'd0, 34, 33);
`endif
    runDivide("remu 100/7", MD_REMU, 32'd100, 32'd7, 32'd2, 34, 33);

    // Downstream stall while the divider sits in DONE
    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b1, MD_DIVU, 1'b0, 3'b0, 32'd100, 32'd7, 0, 2'd0, 2'd0);
    repeat (33) stepClock();
    checkOutput("done stall low", 32'(ex_stall_out), 32'd0);
    mem_stall_in = 1'b1;
    #1;
    checkOutput("done mem stall high", 32'(ex_stall_out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput("done held valid", 32'(ex_valid_out), 32'd0);
      checkOutput("done held reg_write", 32'(ex_reg_write_out), 32'd0);
    end
    mem_stall_in = 1'b0;
    stepClock();
    checkOutput("done emit valid", 32'(ex_valid_out), 32'd1);
    checkOutput("done emit result", ex_result_out, 32'd14);
    applyStimulus(1'b0, ALU_ADD, 1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 0, 0, 0, 2'd0, 2'd0);
    stepClock();
    checkOutput("done emitted once", 32'(ex_valid_out), 32'd0);

    // Flush during BUSY aborts the divide
    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b1, MD_DIV, 1'b0, 3'b0, 32'hFFFF_FFF9, 32'd2, 0, 2'd0, 2'd0);
    repeat (10) stepClock();
    checkOutput("busy stall", 32'(ex_stall_out), 32'd1);
    flush_in = 1'b1;
    stepClock();
    flush_in = 1'b0;
    checkOutput("flush valid", 32'(ex_valid_out), 32'd0);
    applyStimulus(1'b0, ALU_ADD, 1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 0, 0, 0, 2'd0, 2'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (ex_stall_out || ex_valid_out) bad++;
      stepClock();
    end
    checkOutput("flush idle afterwards", 32'(bad), 32'd0);

    // Reset mid-divide
    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 32'd5, 32'd7, 32'h20, 2'd0, 2'd0);
    stepClock();
    applyStimulus(1'b1, ALU_ADD, 1'b0, 1'b1, MD_DIVU, 1'b0, 3'b0, 32'd100, 32'd7, 0, 2'd0, 2'd0);
    repeat (5) stepClock();
    applyStimulus(1'b0, ALU_ADD, 1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 0, 0, 0, 2'd0, 2'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst result", ex_result_out, 32'd0);
    checkOutput("rst pc4", ex_pc_plus_4_out, 32'd0);
    checkOutput("rst target", ex_branch_target_out, 32'd0);
    checkOutput("rst mem_to_reg", 32'(ex_mem_to_reg_out), 32'd0);
    checkOutput("rst stall", 32'(ex_stall_out), 32'd0);
    stepClock();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (ex_stall_out || ex_valid_out) bad++;
      stepClock();
    end
    checkOutput("rst no late result", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
